traffic_phase_scheduler: RTL and testbench

- Demand-driven controller for a four-way junction: sequences NS/EW signal heads through green, yellow and all-red clearance.
- Latches pedestrian requests and serves them in an exclusive walk phase; supports NS emergency preemption.
- Sits between the sensors (car detectors, ped button, emergency input) and the lamp drivers.
- Lamp encoding matches the existing light blocks: 3'b001 green, 3'b010 yellow, 3'b100 red.

---
 rtl/traffic_phase_scheduler.sv | 118 +++++++++++
 tb/tb_traffic_phase_scheduler.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/traffic_phase_scheduler.sv
// Four-way junction phase sequencer: NS/EW green-yellow-allred, exclusive ped walk, NS emergency preempt.
// Lamps decode combinationally from the registered phase; no backpressure, sensors are sampled every cycle.
module traffic_phase_scheduler #(
  parameter int CW        = 4,
  parameter int GREEN_MIN = 5,
  parameter int YELLOW    = 2,
  parameter int ALLRED    = 1,
  parameter int PED_WALK  = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ns_car,
  input  logic          ew_car,
  input  logic          ped_req,
  input  logic          emerg,
  output logic [2:0]    NS,
  output logic [2:0]    EW,
  output logic          walk,
  output logic          ped_ack,
  output logic [2:0]    state,
  output logic [CW-1:0] count
);

  typedef enum logic [2:0] {
    NS_G = 3'd0,
    NS_Y = 3'd1,
    RED1 = 3'd2,
    EW_G = 3'd3,
    EW_Y = 3'd4,
    RED2 = 3'd5,
    PED  = 3'd6,
    BAD  = 3'd7
  } phase_t;

  localparam logic [2:0] LAMP_G = 3'b001;
  localparam logic [2:0] LAMP_Y = 3'b010;
  localparam logic [2:0] LAMP_R = 3'b100;

  // Exit thresholds: a phase of duration T leaves on the edge where count == T-1.
  localparam logic [CW-1:0] GREEN_LAST  = CW'(GREEN_MIN - 1);
  localparam logic [CW-1:0] YELLOW_LAST = CW'(YELLOW - 1);
  localparam logic [CW-1:0] ALLRED_LAST = CW'(ALLRED - 1);
  localparam logic [CW-1:0] WALK_LAST   = CW'(PED_WALK - 1);
  localparam logic [CW-1:0] COUNT_MAX   = {CW{1'b1}};

  phase_t        st_q, st_d;
  logic [CW-1:0] count_q;
  logic          ped_pending_q;
  logic          last_dir_q;
  logic          ped_ack_q;

  always_comb begin
    st_d = st_q;
    case (st_q)
      NS_G: if (!emerg && count_q >= GREEN_LAST && (ew_car || ped_pending_q)) st_d = NS_Y;
      NS_Y: if (count_q >= YELLOW_LAST) st_d = RED1;
      RED1: if (count_q >= ALLRED_LAST) st_d = ped_pending_q ? PED : EW_G;
      // Emergency cuts EW green short immediately, still via yellow.
      EW_G: if (emerg || (count_q >= GREEN_LAST && (ns_car || ped_pending_q))) st_d = EW_Y;
      EW_Y: if (count_q >= YELLOW_LAST) st_d = RED2;
      RED2: if (count_q >= ALLRED_LAST) st_d = (ped_pending_q && !emerg) ? PED : NS_G;
      PED:  if (count_q >= WALK_LAST) st_d = last_dir_q ? NS_G : EW_G;
      default: st_d = NS_G;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st_q          <= NS_G;
      count_q       <= '0;
      ped_pending_q <= 1'b0;
      last_dir_q    <= 1'b0;
      ped_ack_q     <= 1'b0;
    end else begin
      st_q <= st_d;
      if (st_d != st_q)
        count_q <= '0;
      else if (count_q != COUNT_MAX)
        count_q <= count_q + 1'b1;

      // Entering the walk phase clears the latch even if the button is pressed on that edge.
      if (st_d == PED && st_q != PED)
        ped_pending_q <= 1'b0;
      else if (ped_req && st_q != PED)
        ped_pending_q <= 1'b1;

      if (st_q == NS_G)
        last_dir_q <= 1'b0;
      else if (st_q == EW_G)
        last_dir_q <= 1'b1;

      ped_ack_q <= (st_d == PED) && (st_q != PED);
    end
  end

  always_comb begin
    NS   = LAMP_R;
    EW   = LAMP_R;
    walk = 1'b0;
    case (st_q)
      NS_G: NS = LAMP_G;
      NS_Y: NS = LAMP_Y;
      EW_G: EW = LAMP_G;
      EW_Y: EW = LAMP_Y;
      PED:  walk = 1'b1;
      BAD: begin
        NS = 3'b000;
        EW = 3'b000;
      end
      default: ;
    endcase
  end

  assign state   = st_q;
  assign count   = count_q;
  assign ped_ack = ped_ack_q;

endmodule

// File: tb/tb_traffic_phase_scheduler.sv
// Directed bench for traffic_phase_scheduler: stimulus queues expected phase/count/ack per cycle,
// a negedge monitor pops and compares against the DUT outputs.
module tb_traffic_phase_scheduler;

  localparam int CW = 4;

  localparam logic [2:0] S_NSG  = 3'd0;
  localparam logic [2:0] S_NSY  = 3'd1;
  localparam logic [2:0] S_RED1 = 3'd2;
  localparam logic [2:0] S_EWG  = 3'd3;
  localparam logic [2:0] S_EWY  = 3'd4;
  localparam logic [2:0] S_RED2 = 3'd5;
  localparam logic [2:0] S_PED  = 3'd6;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          ns_car = 1'b0;
  logic          ew_car = 1'b0;
  logic          ped_req = 1'b0;
  logic          emerg = 1'b0;
  logic [2:0]    ns_lamp;
  logic [2:0]    ew_lamp;
  logic          walk;
  logic          ped_ack;
  logic [2:0]    state;
  logic [CW-1:0] count;

  typedef struct {
    logic [2:0]    st;
    logic [CW-1:0] cnt;
    logic          ack;
    int            tid;
  } exp_t;

  exp_t exp_q[$];
  exp_t cur;
  int   tid = 0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  traffic_phase_scheduler #(
    .CW(CW), .GREEN_MIN(5), .YELLOW(2), .ALLRED(1), .PED_WALK(4)
  ) dut (
    .clk(clk), .rst(rst), .ns_car(ns_car), .ew_car(ew_car), .ped_req(ped_req), .emerg(emerg),
    .NS(ns_lamp), .EW(ew_lamp), .walk(walk), .ped_ack(ped_ack), .state(state), .count(count)
  );

  // Lamp table for each phase code: {NS, EW, walk}.
  function automatic logic [6:0] lamps_of(input logic [2:0] st);
    case (st)
      S_NSG:   return {3'b001, 3'b100, 1'b0};
      S_NSY:   return {3'b010, 3'b100, 1'b0};
      S_RED1:  return {3'b100, 3'b100, 1'b0};
      S_EWG:   return {3'b100, 3'b001, 1'b0};
      S_EWY:   return {3'b100, 3'b010, 1'b0};
      S_RED2:  return {3'b100, 3'b100, 1'b0};
      S_PED:   return {3'b100, 3'b100, 1'b1};
      default: return 7'b0;
    endcase
  endfunction

  // One clock edge; queue what the DUT must show during the following cycle.
  task automatic tick(input logic [2:0] st, input int cnt, input logic ack = 1'b0);
    exp_t e;
    @(posedge clk);
    #1;
    e.st  = st;
    e.cnt = CW'(cnt);
    e.ack = ack;
    e.tid = tid;
    exp_q.push_back(e);
  endtask

  // n consecutive cycles in one phase, count running from c0.
  task automatic run(input logic [2:0] st, input int c0, input int n);
    for (int i = 0; i < n; i++) tick(st, c0 + i);
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      logic [6:0] lp;
      cur = exp_q.pop_front();
      lp  = lamps_of(cur.st);
      checks++;
      if (state !== cur.st || count !== cur.cnt || ped_ack !== cur.ack ||
          ns_lamp !== lp[6:4] || ew_lamp !== lp[3:1] || walk !== lp[0]) begin
        errors++;
        $display("FAIL phase_chk test%0d t=%0t: got state=%0d count=%0d NS=%b EW=%b walk=%b ack=%b, want state=%0d count=%0d NS=%b EW=%b walk=%b ack=%b",
                 cur.tid, $time, state, count, ns_lamp, ew_lamp, walk, ped_ack,
                 cur.st, cur.cnt, lp[6:4], lp[3:1], lp[0], cur.ack);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    // 1: reset state, then idle NS_G rest with count saturating.
    tid = 1;
    rst = 1'b1;
    tick(S_NSG, 0);
    tick(S_NSG, 0);
    rst = 1'b0;
    for (int i = 1; i <= 40; i++) tick(S_NSG, (i > 15) ? 15 : i);

    // 2: EW demand from reset, EW hold without NS demand, NS demand at cycle 20.
    tid = 2;
    rst = 1'b1;
    tick(S_NSG, 0);
    rst = 1'b0;
    ew_car = 1'b1;
    run(S_NSG, 1, 4);
    run(S_NSY, 0, 2);
    run(S_RED1, 0, 1);
    run(S_EWG, 0, 13);
    ns_car = 1'b1;
    run(S_EWY, 0, 2);
    run(S_RED2, 0, 1);
    run(S_NSG, 0, 1);

    // 3: single-cycle ped press during NS_G, served as walk then EW_G.
    tid = 3;
    ns_car = 1'b0;
    ew_car = 1'b0;
    ped_req = 1'b1;
    run(S_NSG, 1, 1);
    ped_req = 1'b0;
    run(S_NSG, 2, 3);
    run(S_NSY, 0, 2);
    run(S_RED1, 0, 1);
    tick(S_PED, 0, 1'b1);
    run(S_PED, 1, 3);
    run(S_EWG, 0, 6);

    // 4: emergency at EW_G count=1, then NS_G held under emergency.
    tid = 4;
    ns_car = 1'b1;
    run(S_EWY, 0, 2);
    run(S_RED2, 0, 1);
    run(S_NSG, 0, 1);
    ns_car = 1'b0;
    ew_car = 1'b1;
    run(S_NSG, 1, 4);
    run(S_NSY, 0, 2);
    run(S_RED1, 0, 1);
    run(S_EWG, 0, 2);
    emerg = 1'b1;
    run(S_EWY, 0, 2);
    run(S_RED2, 0, 1);
    run(S_NSG, 0, 10);
    emerg = 1'b0;
    run(S_NSY, 0, 2);
    run(S_RED1, 0, 1);
    run(S_EWG, 0, 1);

    // 5: ped pending with emergency during RED2 defers the walk to after NS.
    tid = 5;
    ped_req = 1'b1;
    run(S_EWG, 1, 1);
    ped_req = 1'b0;
    run(S_EWG, 2, 3);
    run(S_EWY, 0, 2);
    run(S_RED2, 0, 1);
    emerg = 1'b1;
    run(S_NSG, 0, 1);
    emerg = 1'b0;
    ew_car = 1'b0;
    run(S_NSG, 1, 4);
    run(S_NSY, 0, 2);
    run(S_RED1, 0, 1);
    tick(S_PED, 0, 1'b1);
    run(S_PED, 1, 2);

    // 6: reset mid-walk; afterwards NS_G rests, so no request survived.
    tid = 6;
    rst = 1'b1;
    tick(S_NSG, 0);
    rst = 1'b0;
    run(S_NSG, 1, 6);

    repeat (2) @(negedge clk);
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left unchecked, want 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
